// File: rtl/wb_uart_master_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the UART-driven Wishbone master.
package wb_uart_master_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam logic [7:0] RSP_BAD = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_RDATA
    } wum_state_e;

endpackage

// File: rtl/wb_uart_master.sv
// Byte-stream command parser issuing single pipelined Wishbone reads/writes, answering on a tx stream.
// Latency: bus request registered the cycle after the last frame byte; status byte the cycle after ack/err.
// Backpressure: rx stalls outside IDLE/ADDR/DATA; each tx byte is held until tx_ready_i.
module wb_uart_master
    import wb_uart_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_stall_i
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    wum_state_e    state;
    logic [1:0]    cnt;
    logic          is_rd;
    logic          rd_ok;
    logic [31:0]   adr_sr;
    logic [31:0]   dat_sr;
    logic [31:0]   rd_sr;
    logic [TW-1:0] tmo;

    logic        rx_fire;
    logic        tx_fire;
    logic        bus_take;
    logic        tmo_hit;
    logic [31:0] adr_shift;
    logic [31:0] dat_shift;

    assign rx_fire   = rx_valid_i && rx_ready_o;
    assign tx_fire   = tx_valid_o && tx_ready_i;
    assign adr_shift = {adr_sr[23:0], rx_data_i};
    assign dat_shift = {dat_sr[23:0], rx_data_i};
    // A response during REQ only counts once the strobe is actually accepted.
    assign bus_take  = (wb_ack_i || wb_err_i) && ((state == S_WAIT) || !wb_stall_i);
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo == TMO_LAST);
    assign wb_sel_o  = 4'hF;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            is_rd      <= 1'b0;
            rd_ok      <= 1'b0;
            adr_sr     <= '0;
            dat_sr     <= '0;
            rd_sr      <= '0;
            tmo        <= '0;
            rx_ready_o <= 1'b0;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rx_ready_o <= 1'b1;
                    if (rx_fire) begin
                        if (rx_data_i == OP_WR || rx_data_i == OP_RD) begin
                            is_rd <= (rx_data_i == OP_RD);
                            cnt   <= '0;
                            state <= S_ADDR;
                        end else begin
                            rd_ok      <= 1'b0;
                            rx_ready_o <= 1'b0;
                            tx_valid_o <= 1'b1;
                            tx_data_o  <= RSP_BAD;
                            state      <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        adr_sr <= adr_shift;
                        cnt    <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (is_rd) begin
                                rx_ready_o <= 1'b0;
                                wb_adr_o   <= adr_shift[ADDR_W-1:0];
                                wb_cyc_o   <= 1'b1;
                                wb_stb_o   <= 1'b1;
                                wb_we_o    <= 1'b0;
                                tmo        <= '0;
                                state      <= S_REQ;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        dat_sr <= dat_shift;
                        cnt    <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            rx_ready_o <= 1'b0;
                            wb_adr_o   <= adr_sr[ADDR_W-1:0];
                            wb_dat_o   <= dat_shift;
                            wb_cyc_o   <= 1'b1;
                            wb_stb_o   <= 1'b1;
                            wb_we_o    <= 1'b1;
                            tmo        <= '0;
                            state      <= S_REQ;
                        end
                    end
                end
                S_REQ, S_WAIT: begin
                    tmo <= tmo + 1'b1;
                    if (bus_take || tmo_hit) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        wb_we_o    <= 1'b0;
                        tx_valid_o <= 1'b1;
                        state      <= S_RESP;
                        // Error outranks a simultaneous ack.
                        if (bus_take && !wb_err_i) begin
                            rd_ok     <= 1'b1;
                            rd_sr     <= wb_dat_i;
                            tx_data_o <= RSP_OK;
                        end else begin
                            rd_ok     <= 1'b0;
                            tx_data_o <= RSP_ERR;
                        end
                    end else if (state == S_REQ && !wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_RESP: begin
                    if (tx_fire) begin
                        if (is_rd && rd_ok) begin
                            tx_data_o <= rd_sr[31:24];
                            rd_sr     <= {rd_sr[23:0], 8'h00};
                            cnt       <= '0;
                            state     <= S_RDATA;
                        end else begin
                            tx_valid_o <= 1'b0;
                            rx_ready_o <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                end
                S_RDATA: begin
                    if (tx_fire) begin
                        if (cnt == 2'd3) begin
                            tx_valid_o <= 1'b0;
                            rx_ready_o <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            tx_data_o <= rd_sr[31:24];
                            rd_sr     <= {rd_sr[23:0], 8'h00};
                            cnt       <= cnt + 2'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_master.sv
// Directed frame table plus reset sequences for wb_uart_master (TIMEOUT_CYCLES=8).
module tb_wb_uart_master;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_stall_i = 1'b0;

    wb_uart_master #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
    );

    always #5 clk = ~clk;

    // mode: 0 ack, 1 err, 2 no response, 3 ack+err together
    typedef struct {
        logic [71:0] frm;  int nb;
        int stall; int mode; int lat; int hold;
        logic [31:0] rdata;
        logic [47:0] etx;  int ntx;
        int estb; int ecyc;
        logic [31:0] eadr; logic ewe; logic [31:0] edat;
        int eturn;
    } vec_t;

    int total = 0;
    int bad = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    int          cyc_no = 0;
    int          rx_pops, last_rx_cyc, last_tx_cyc, first_stb, stb_cnt, cyc_cnt, n_txn;
    int          stall_left, mode, lat, hold;
    logic [31:0] rdata, cap_adr, cap_dat;
    logic        cap_we;
    logic        pend = 1'b0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_txd;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic respond();
        if (mode == 1 || mode == 3) wb_err_i = 1'b1;
        if (mode == 0 || mode == 3) begin
            wb_ack_i = 1'b1;
            wb_dat_i = rdata;
        end
    endtask

    // Stream source/sink and Wishbone slave; inputs set here apply to the next rising edge.
    always @(negedge clk) begin
        cyc_no++;
        if (!rst_i) begin
            rx_valid_i = 1'b0; tx_ready_i = 1'b0;
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;
            pend = 1'b0; prev_hold = 1'b0;
        end else begin
            if (prev_hold) check("tx_hold", {tx_valid_o, tx_data_o}, {1'b1, prev_txd});
            tx_ready_i = (hold != 0) ? cyc_no[0] : 1'b1;
            if (tx_valid_o && tx_ready_i) begin
                tx_q.push_back(tx_data_o);
                last_tx_cyc = cyc_no;
            end
            prev_hold = tx_valid_o && !tx_ready_i;
            prev_txd  = tx_data_o;

            rx_valid_i = (rx_q.size() > 0);
            rx_data_i  = rx_valid_i ? rx_q[0] : 8'h00;
            if (rx_valid_i && rx_ready_o) begin
                void'(rx_q.pop_front());
                rx_pops++;
                last_rx_cyc = cyc_no;
            end

            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = 32'h0;
            if (wb_cyc_o) cyc_cnt++;
            if (wb_stb_o) begin
                stb_cnt++;
                if (first_stb < 0) begin
                    first_stb = cyc_no;
                    cap_adr = wb_adr_o; cap_we = wb_we_o; cap_dat = wb_dat_o;
                end
            end
            if (pend) begin
                respond();
                pend = 1'b0;
            end else if (wb_stb_o) begin
                if (stall_left > 0) begin
                    wb_stall_i = 1'b1;
                    stall_left--;
                end else begin
                    n_txn++;
                    if (mode != 2) begin
                        if (lat == 0) respond();
                        else pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic start(input vec_t v);
        tx_q.delete();
        rx_pops = 0; last_rx_cyc = 0; last_tx_cyc = 0; first_stb = -1;
        stb_cnt = 0; cyc_cnt = 0; n_txn = 0;
        stall_left = v.stall; mode = v.mode; lat = v.lat; hold = v.hold; rdata = v.rdata;
        for (int k = 0; k < v.nb; k++) rx_q.push_back(v.frm[8*(v.nb-1-k) +: 8]);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int waited;
        logic [7:0] got;
        @(posedge clk);
        start(v);
        waited = 0;
        while (tx_q.size() < v.ntx && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        repeat (6) @(posedge clk);
        check({tag, "_ntx"}, tx_q.size(), v.ntx);
        for (int k = 0; k < v.ntx; k++) begin
            got = (k < tx_q.size()) ? tx_q[k] : 8'hxx;
            check($sformatf("%s_tx%0d", tag, k), got, v.etx[8*(v.ntx-1-k) +: 8]);
        end
        check({tag, "_stb_cycles"}, stb_cnt, v.estb);
        check({tag, "_cyc_cycles"}, cyc_cnt, v.ecyc);
        check({tag, "_n_txn"}, n_txn, 1);
        check({tag, "_req_lat"}, first_stb - last_rx_cyc, 1);
        check({tag, "_adr"}, cap_adr, v.eadr);
        check({tag, "_we"}, cap_we, v.ewe);
        if (v.ewe) check({tag, "_dat"}, cap_dat, v.edat);
        if (v.eturn >= 0) check({tag, "_turn"}, last_tx_cyc - last_rx_cyc, v.eturn);
    endtask

    vec_t vt[8];

    initial begin
        int waited;
        vt[0] = '{72'h57_01_00_00_10_DE_AD_BE_EF, 9, 0, 0, 1, 0, 32'h0, 48'h4B, 1,
                  1, 2, 32'h01000010, 1'b1, 32'hDEADBEEF, 3};
        vt[1] = '{72'h52_00_00_00_04, 5, 3, 0, 1, 0, 32'h12345678, 48'h4B_12_34_56_78, 5,
                  4, 5, 32'h4, 1'b0, 32'h0, 10};
        vt[2] = '{72'h52_00_00_00_08, 5, 0, 1, 1, 0, 32'h0, 48'h45, 1,
                  1, 2, 32'h8, 1'b0, 32'h0, 3};
        vt[3] = '{72'h52_00_00_00_0C, 5, 0, 2, 1, 0, 32'h0, 48'h45, 1,
                  1, 8, 32'hC, 1'b0, 32'h0, 9};
        vt[4] = '{72'h52_00_00_00_10, 5, 0, 0, 0, 0, 32'hCAFEF00D, 48'h4B_CA_FE_F0_0D, 5,
                  1, 1, 32'h10, 1'b0, 32'h0, 6};
        vt[5] = '{72'hAA_52_00_00_00_14, 6, 0, 0, 1, 0, 32'hA5A50102, 48'h3F_4B_A5_A5_01_02, 6,
                  1, 2, 32'h14, 1'b0, 32'h0, 7};
        vt[6] = '{72'h57_00_00_00_20_01_02_03_04, 9, 1, 0, 1, 1, 32'h0, 48'h4B, 1,
                  2, 3, 32'h20, 1'b1, 32'h01020304, -1};
        vt[7] = '{72'h57_80_00_00_00_11_22_33_44, 9, 0, 3, 1, 0, 32'h0, 48'h45, 1,
                  1, 2, 32'h80000000, 1'b1, 32'h11223344, 3};
        hold = 0; mode = 0; lat = 1; stall_left = 0; rdata = 32'h0;

        #3;
        check("rst_ctrl", {rx_ready_o, tx_valid_o, wb_cyc_o, wb_stb_o, wb_we_o}, 5'b0);
        check("rst_txd", tx_data_o, 8'h00);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_i = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("v%0d", i));

        // Reset after opcode + two address bytes; partial frame must be dropped.
        @(posedge clk);
        start(vt[4]);
        waited = 0;
        while (rx_pops < 3 && waited < 50) begin @(posedge clk); waited++; end
        check("r1_reached", rx_pops, 3);
        #2 rst_i = 1'b0;
        rx_q.delete();
        #1;
        check("r1_ctrl", {rx_ready_o, tx_valid_o, wb_cyc_o, wb_stb_o}, 4'b0);
        repeat (3) @(posedge clk);
        #2 rst_i = 1'b1;
        run_vec(vt[4], "r1");

        // Reset while the bus cycle waits for a response: cyc must drop at once.
        @(posedge clk);
        start(vt[3]);
        waited = 0;
        while (!(wb_cyc_o && !wb_stb_o) && waited < 50) begin @(posedge clk); waited++; end
        check("r2_wait_seen", {wb_cyc_o, wb_stb_o}, 2'b10);
        @(posedge clk);
        #2 rst_i = 1'b0;
        rx_q.delete();
        #1;
        check("r2_ctrl", {rx_ready_o, tx_valid_o, wb_cyc_o, wb_stb_o, wb_we_o}, 5'b0);
        check("r2_adr", wb_adr_o, 32'h0);
        repeat (3) @(posedge clk);
        #2 rst_i = 1'b1;
        run_vec(vt[0], "r2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_uart_master.md
# wb_uart_master

Wishbone bus master driven by a byte-stream command protocol: it parses read/write frames arriving from a UART receiver, issues single pipelined Wishbone transactions on a crossbar master port, and returns a status/data byte stream to a UART transmitter. It sits beside the CPU as a second crossbar master (`NM=2`). It provides a debug/load path into RAM and peripherals that is independent of firmware.

## Interface
- `TIMEOUT_CYCLES`, default 1023: bus cycles to wait for ack/err after `wb_cyc_o` rises; 0 disables the timeout.
- `ADDR_W`, default 32: Wishbone address width; frames always carry 4 address bytes, and the upper bytes are truncated.
- `clk_i` input 1: single clock for bus and stream logic.
- `rst_i` input 1: reset, asynchronous assert, active-low.
- `rx_data_i` input 8: command byte.
- `rx_valid_i` input 1: command byte valid.
- `rx_ready_o` output 1: command byte accepted when `rx_valid_i && rx_ready_o`.
- `tx_data_o` output 8: response byte.
- `tx_valid_o` output 1: response byte valid.
- `tx_ready_i` input 1: downstream accepted the response byte.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` output 1 each: Wishbone pipelined master controls.
- `wb_adr_o` output `ADDR_W`: bus address.
- `wb_dat_o` output 32: write data.
- `wb_sel_o` output 4: byte select, constant 4'hF.
- `wb_dat_i` input 32: read data.
- `wb_ack_i`, `wb_err_i`, `wb_stall_i` input 1 each: slave response and stall.

## Operation
- **Frame formats.** All multi-byte fields are MSB first.
  - Write: `0x57`, A3..A0, D3..D0.
  - Read: `0x52`, A3..A0.
- **Responses.**
  - Write success: `0x4B`.
  - Read success: `0x4B`, then D3..D0.
  - Bus error or timeout: a single `0x45`; a read sends no data bytes.
  - Unknown opcode: the byte is consumed and a single `0x3F` is sent.
- **FSM states:**
  - IDLE: waiting for an opcode.
  - ADDR: collecting address bytes with a 2-bit byte counter.
  - DATA: collecting write-data bytes with a 2-bit byte counter.
  - REQ: `cyc` and `stb` high until not stalled.
  - WAIT: `cyc` high, `stb` low, waiting for ack/err.
  - RESP: sending the status byte.
  - RDATA: sending 4 data bytes.
- **Transitions:**
  - IDLE to ADDR on a valid opcode.
  - IDLE to RESP (with `0x3F`) on an invalid opcode.
  - ADDR, after its 4th byte, goes to DATA for a write or REQ for a read.
  - DATA, after its 4th byte, goes to REQ.
  - REQ to WAIT when `!wb_stall_i`.
  - REQ or WAIT to RESP on ack, err or timeout.
  - RESP to RDATA when the request was a read with ack, else to IDLE.
  - RDATA to IDLE after D0 is accepted.
- **Stream handshakes.**
  - `rx_ready_o` is 1 only in IDLE, ADDR and DATA.
  - `tx_valid_o` is 1 only in RESP and RDATA.
  - A tx byte is held stable until `tx_ready_i`.
- **Bus response handling.**
  - `wb_ack_i`/`wb_err_i` are honoured in REQ (if `!wb_stall_i` in the same cycle) and in WAIT; they are ignored in all other states.
  - When ack and err are both asserted, err wins.
  - Read data is captured from `wb_dat_i` on the ack cycle.
- **Timeout counter.** Cleared on entry to REQ and incremented each cycle in REQ/WAIT. Reaching `TIMEOUT_CYCLES` drops `cyc`/`stb` and forces `0x45`.
- **Reset.**
  - All outputs reset to 0, the FSM to IDLE, and the counters to 0.
  - Reset mid-transaction drops `cyc` immediately, asynchronously.
  - A partially received frame is discarded.

## Timing
- Last frame byte accepted at cycle N: `wb_cyc_o`, `wb_stb_o`, `wb_adr_o`, `wb_we_o` and `wb_dat_o` are registered and valid at N+1.
- `wb_stb_o` is high for exactly (stall cycles + 1) cycles.
- `wb_cyc_o` falls on the cycle after ack/err, i.e. it is low at M+1 for ack at M.
- Ack at cycle M: `tx_valid_o=1` with `0x4B` at M+1.
- Each subsequent byte is valid the cycle after the previous byte's handshake, giving zero-bubble back-to-back output when `tx_ready_i=1`.
- Minimum read turnaround with no stall and ack at N+1: `0x4B` at N+2, D0 accepted at N+6.
- Timeout: `wb_cyc_o` is high for exactly `TIMEOUT_CYCLES` cycles, then `0x45` appears the next cycle.

## Structure
- Package `wb_uart_master_pkg` holds:
  - opcode constants `OP_WR=8'h57` and `OP_RD=8'h52`;
  - response constants `RSP_OK=8'h4B`, `RSP_ERR=8'h45` and `RSP_BAD=8'h3F`;
  - the state enum `wum_state_e`.
- Single module with no sub-module. The shift registers for address, data and response, the byte counter and the timeout counter are all inline.

## Test plan
- Write frame `57 01 00 00 10 DE AD BE EF`, slave acks 1 cycle after `stb` → one bus cycle with `adr=0x01000010`, `dat=0xDEADBEEF`, `we=1`, `sel=F`; tx stream is `4B`.
- Read frame `52 00 00 00 04`, slave stalls 3 cycles, then acks with `0x12345678` → `stb` high for 4 cycles; tx stream is `4B 12 34 56 78`, MSB first.
- Read frame with slave `err` asserted → tx is `45` only, and `cyc` drops the next cycle.
- `TIMEOUT_CYCLES=8`, slave never responds → `cyc` high for exactly 8 cycles; tx is `45`; the next frame is processed normally.
- Opcode `0xAA` followed by a valid read → first `3F`, then a correct read response.
- `rst_i` asserted low mid-frame (after 2 address bytes) and also during WAIT → outputs go to 0 immediately; a fresh full frame after release completes correctly.
